// File: rtl/seq_shift_reg_pkg.sv
// Shared constants for the sequential shift register: state encodings,
// shift-direction codes and default geometry.
package seq_shift_reg_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultCntW  = 5;

  // Kept as plain constants so older blocks can compare against raw codes.
  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StShift = 2'b01;
  localparam logic [1:0] StFin   = 2'b10;

  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

endpackage

// File: rtl/seq_shift_reg_shift_step.sv
// Combinational single-bit shifter: one left or right shift of q_i,
// plus the bit that falls off the end.
module seq_shift_reg_shift_step
  import seq_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             dir_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  logic fill;

  // Sign fill only matters for right shifts; left shifts always bring in zero.
  assign fill = arith_i & q_i[WIDTH-1];

  always_comb begin
    q_o    = q_i;
    sout_o = 1'b0;
    if (dir_i == DirRight) begin
      q_o    = {fill, q_i[WIDTH-1:1]};
      sout_o = q_i[0];
    end else begin
      q_o    = {q_i[WIDTH-2:0], 1'b0};
      sout_o = q_i[WIDTH-1];
    end
  end

endmodule

// File: rtl/seq_shift_reg.sv
// Multi-cycle shift register: parallel load, then shift one bit per clock
// under a START/BUSY/DONE handshake.
module seq_shift_reg
  import seq_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             START,
  input  logic             DIR,
  input  logic             ARITH,
  input  logic [CNT_W-1:0] AMT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;

  logic [WIDTH-1:0] step_q;
  logic             step_sout;

  seq_shift_reg_shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .q_i     (q_q),
    .dir_i   (dir_q),
    .arith_i (arith_q),
    .q_o     (step_q),
    .sout_o  (step_sout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    q_d     = q_q;
    sout_d  = sout_q;
    case (state_q)
      StIdle: begin
        // LOAD has priority; a simultaneous START is dropped.
        if (LOAD) begin
          q_d = D;
        end else if (START) begin
          dir_d   = DIR;
          arith_d = ARITH;
          cnt_d   = AMT;
          state_d = (AMT == '0) ? StFin : StShift;
        end
      end
      StShift: begin
        q_d    = step_q;
        sout_d = step_sout;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= DirLeft;
      arith_q <= 1'b0;
      q_q     <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
    end
  end

  assign Q    = q_q;
  assign SOUT = sout_q;
  assign BUSY = (state_q == StShift);
  assign DONE = (state_q == StFin);

endmodule

// File: tb/tb_seq_shift_reg.sv
// Scoreboard bench for seq_shift_reg: each shift pushes its expected result,
// a monitor pops and compares whenever DONE is presented.
module tb_seq_shift_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  logic          C = 1'b0;
  logic          R = 1'b1;
  logic [W-1:0]  D = '0;
  logic          LOAD = 1'b0;
  logic          START = 1'b0;
  logic          DIR = 1'b0;
  logic          ARITH = 1'b0;
  logic [CW-1:0] AMT = '0;
  logic [W-1:0]  Q;
  logic          SOUT;
  logic          BUSY;
  logic          DONE;

  typedef struct packed {
    logic [W-1:0] q;
    logic         sout;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_shift_reg #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .C     (C),
    .R     (R),
    .D     (D),
    .LOAD  (LOAD),
    .START (START),
    .DIR   (DIR),
    .ARITH (ARITH),
    .AMT   (AMT),
    .Q     (Q),
    .SOUT  (SOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 C = ~C;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge C) begin
    if (!R && DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_q", Q, e.q);
        chk("done_sout", {31'd0, SOUT}, {31'd0, e.sout});
      end
    end
  end

  task automatic do_load(input logic [W-1:0] d);
    @(posedge C); #1;
    LOAD = 1'b1;
    D    = d;
    @(posedge C); #1;
    LOAD = 1'b0;
    @(negedge C);
    chk("load_q", Q, d);
    chk("load_busy", {31'd0, BUSY}, 32'd0);
    chk("load_done", {31'd0, DONE}, 32'd0);
  endtask

  // Issue START, push expectation, then check BUSY length and single-cycle DONE.
  task automatic do_op(input logic dir, input logic arith, input int amt,
                       input logic [W-1:0] exp_q, input logic exp_sout, input bit disturb);
    int busy_n;
    bit seen;
    exp_t e;
    busy_n = 0;
    seen   = 1'b0;
    e.q    = exp_q;
    e.sout = exp_sout;
    sb.push_back(e);
    @(posedge C); #1;
    START = 1'b1;
    DIR   = dir;
    ARITH = arith;
    AMT   = CW'(amt);
    @(posedge C); #1;
    START = 1'b0;
    DIR   = ~dir;
    ARITH = ~arith;
    AMT   = '1;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge C);
      if (DONE) begin
        seen = 1'b1;
      end else if (BUSY) begin
        busy_n++;
        if (disturb && busy_n == 2) begin
          LOAD  = 1'b1;
          START = 1'b1;
          D     = '1;
        end else if (disturb && busy_n == 3) begin
          LOAD  = 1'b0;
          START = 1'b0;
        end
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_cycles", busy_n, amt);
    @(negedge C);
    chk("done_one_cycle", {31'd0, DONE}, 32'd0);
    chk("idle_after", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int done_n;
    // Power-up reset held for two edges.
    R = 1'b1;
    @(posedge C); #1;
    chk("rst_q", Q, 32'h0);
    chk("rst_sout", {31'd0, SOUT}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    @(posedge C); #1;
    R = 1'b0;

    do_load(32'hA5A50F0F);

    do_load(32'h00000001);
    do_op(1'b0, 1'b0, 4, 32'h00000010, 1'b0, 1'b0);

    do_load(32'h80000000);
    do_op(1'b1, 1'b1, 3, 32'hF0000000, 1'b0, 1'b0);
    do_load(32'h80000000);
    do_op(1'b1, 1'b0, 3, 32'h10000000, 1'b0, 1'b0);

    do_load(32'h00000003);
    do_op(1'b1, 1'b0, 1, 32'h00000001, 1'b1, 1'b0);
    // AMT=0 leaves both Q and SOUT where they were.
    do_op(1'b0, 1'b0, 0, 32'h00000001, 1'b1, 1'b0);

    do_load(32'hC0000000);
    do_op(1'b0, 1'b1, 1, 32'h80000000, 1'b1, 1'b0);

    do_load(32'h80000000);
    do_op(1'b1, 1'b1, 31, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_load(32'hFFFFFFFF);
    do_op(1'b1, 1'b0, 31, 32'h00000001, 1'b1, 1'b0);
    do_load(32'hFFFFFFFF);
    do_op(1'b0, 1'b0, 31, 32'h80000000, 1'b1, 1'b0);

    // LOAD and START together: load wins, no shift follows.
    @(posedge C); #1;
    LOAD  = 1'b1;
    START = 1'b1;
    AMT   = CW'(3);
    D     = 32'h12345678;
    @(posedge C); #1;
    LOAD  = 1'b0;
    START = 1'b0;
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      if (BUSY || DONE) done_n++;
    end
    chk("load_start_q", Q, 32'h12345678);
    chk("load_start_noshift", done_n, 0);

    do_load(32'h00000001);
    do_op(1'b0, 1'b0, 5, 32'h00000020, 1'b0, 1'b1);

    // Reset two cycles into a shift aborts it with no DONE.
    do_load(32'h00000001);
    @(posedge C); #1;
    START = 1'b1;
    DIR   = 1'b0;
    AMT   = CW'(10);
    @(posedge C); #1;
    START = 1'b0;
    @(posedge C); #1;
    R = 1'b1;
    @(posedge C); #1;
    chk("abort_q", Q, 32'h0);
    chk("abort_sout", {31'd0, SOUT}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    @(posedge C); #1;
    R = 1'b0;
    done_n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge C);
      if (DONE || BUSY) done_n++;
    end
    chk("abort_no_done", done_n, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shift_reg.md
Name: seq_shift_reg

Overview:
- Multi-cycle shift register built around the team's D flip-flop stage.
- It captures a parallel word, then shifts it by a requested amount at one bit per clock, under a start/busy/done handshake.
- It sits directly downstream of the flip-flop storage stage and is the basis for the datapath's sequential shifter.

Parameters:
WIDTH, 32, data word width in bits
CNT_W, 5, width of the shift-amount field; must satisfy 2**CNT_W >= WIDTH

Ports:
C  input  1  clock; all state updates on rising edge
R  input  1  reset; synchronous, active-high
D  input  WIDTH  parallel load data
LOAD  input  1  load D into Q (accepted in IDLE only)
START  input  1  begin shift operation (accepted in IDLE only)
DIR  input  1  0 = shift left, 1 = shift right; sampled with START
ARITH  input  1  1 = right shift replicates MSB; sampled with START; ignored when DIR=0
AMT  input  CNT_W  number of single-bit shifts; sampled with START
Q  output  WIDTH  register contents
SOUT  output  1  last bit shifted out
BUSY  output  1  high while shifting
DONE  output  1  one-cycle completion pulse

Behaviour:
- Clock is C. Reset is R, synchronous and active-high, and has priority over every other input.
- Reset values: Q=0, SOUT=0, BUSY=0, DONE=0, state=IDLE, internal counter=0.
- State machine has three states: IDLE, SHIFT, FIN.
- IDLE, LOAD=1: Q<=D at the next edge, with zero added latency. If START is also 1 in the same cycle, LOAD wins and START is dropped.
- IDLE, START=1 with LOAD=0: latch DIR, ARITH and AMT.
  - AMT=0: go to FIN; Q and SOUT are unchanged.
  - AMT>0: go to SHIFT with counter=AMT.
- SHIFT: BUSY=1. Each edge performs one single-bit shift and decrements the counter.
  - When counter=1, perform the final shift and go to FIN.
  - LOAD, START, D, DIR, ARITH and AMT are ignored.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then go to IDLE. LOAD and START are ignored in FIN.
- Latency for AMT=N (N>0): BUSY is high for N cycles starting the cycle after START is sampled. DONE is high in the cycle after the last shift.
- Left shift: Q<={Q[WIDTH-2:0],0} and SOUT<=Q[WIDTH-1].
- Right shift: Q<={fill,Q[WIDTH-1:1]} and SOUT<=Q[0], where fill=Q[WIDTH-1] if ARITH else 0.
- AMT >= WIDTH is legal:
  - Logical shift: Q ends at 0.
  - Arithmetic shift: Q ends all sign bits.
  - SOUT is the last bit shifted out.
- Reset asserted mid-SHIFT or in FIN: the operation aborts, all outputs take reset values at that edge, and no DONE is produced.
- Outputs are registered or decoded from state only; there is no combinational input-to-output path.

Decomposition:
- Shared package holds:
  - State encodings IDLE=2'b00, SHIFT=2'b01, FIN=2'b10.
  - Direction constants DIR_LEFT=0, DIR_RIGHT=1.
  - Default WIDTH and CNT_W constants.
- One natural sub-module, shift_step: combinational single-bit shifter.
  - Inputs: Q, DIR, ARITH.
  - Outputs: next Q and shifted-out bit.
- The FSM, the counter and the Q/SOUT registers stay in seq_shift_reg.

Test Plan:
1. Hold R=1 for 2 edges from power-up, and again 2 cycles into a shift -> Q=0, SOUT=0, BUSY=0, DONE=0 at the first reset edge; no DONE afterwards.
2. IDLE, LOAD=1, D=0xA5A50F0F -> Q=0xA5A50F0F after one edge; BUSY=0; DONE=0.
3. Load 0x00000001, START with AMT=4, DIR=0 -> BUSY high 4 cycles; Q=0x00000010; SOUT=0; DONE high for exactly 1 cycle; then IDLE.
4. Load 0x80000000, START with AMT=3, DIR=1:
   - ARITH=1 -> Q=0xF0000000.
   - ARITH=0 -> Q=0x10000000.
   - In both cases SOUT=0.
5. START with AMT=0 -> BUSY never high; DONE pulses the cycle after START; Q unchanged.
6. Illegal-timing inputs:
   - LOAD and START high together with D=0x12345678 -> Q=0x12345678 and no shift.
   - LOAD and START pulsed during BUSY (AMT=5, DIR=0, from Q=0x1) -> ignored; final Q=0x20.
